float_to_fixed: RTL
===================

Name: float_to_fixed

Overview:
- Downstream stage of the IIR filter. Consumes the filter's 32-bit IEEE-754 single-precision o_signal.
- Converts each sample to a signed fixed-point word for DAC/output logic.
- 3-stage pipeline with valid/ready handshake, saturation, special-value handling and a saturation event counter.

Parameters:
OUT_W, 16, output word width in bits (two's complement), legal 8..31
FRAC_W, 0, fractional bits in output; output = value * 2^FRAC_W, legal 0..OUT_W-1
CNT_W, 16, width of saturation event counter

Ports:
clk  input  1  system clock, all logic on rising edge
reset_l  input  1  asynchronous active-low reset
i_signal  input  32  IEEE-754 single sample (IIR o_signal)
i_valid  input  1  i_signal holds a sample this cycle
i_ready  output  1  block accepts a sample this cycle
o_data  output  OUT_W  signed fixed-point result
o_valid  output  1  o_data valid
o_ready  input  1  downstream accepts o_data
sat_cnt  output  CNT_W  count of saturated samples, sticks at all-ones
nan_flag  output  1  sticky: a NaN was accepted
clr  input  1  synchronous clear of sat_cnt and nan_flag

Behaviour:
- Reset (reset_l=0, async): all stage valids 0, o_valid=0, o_data=0, sat_cnt=0, nan_flag=0.
- Pipeline:
  - Global advance enable en = ~o_valid | o_ready; i_ready = en (combinational).
  - Input transfer: i_valid & i_ready. Output transfer: o_valid & o_ready.
  - All three stages shift together only when en=1; when en=0 every stage register, including o_data/o_valid, holds.
  - Latency: 3 cycles from input transfer to o_valid with o_ready held 1. Throughput: 1 sample/cycle.
  - Bubbles (i_valid=0) propagate as invalid stages. o_data is stable while o_valid=1 and o_ready=0.
- S1 (unpack/classify): sign, exponent e, mantissa m with hidden 1. Classes:
  - zero/denormal (e=0): result 0; -0 and denormals give 0.
  - NaN (e=255, m!=0): result 0, sets nan_flag when the sample leaves S3.
  - Inf (e=255, m=0): saturate by sign.
  - normal: all other encodings.
- S2 (shift): scale k = e-127+FRAC_W.
  - Align the 24-bit significand so its integer part has OUT_W+1 bits.
  - Keep guard bit and sticky OR of the shifted-out bits.
  - If k > OUT_W-1, set pre-overflow.
  - If k < -2, integer part = 0, guard = 0, sticky = 1.
- S3 (round/saturate/sign):
  - Apply the rounding rule to the magnitude, then negate if sign=1.
  - Limits: max = 2^(OUT_W-1)-1, min = -2^(OUT_W-1).
  - Saturate to max/min if pre-overflow, or if the rounded magnitude exceeds max (positive) or 2^(OUT_W-1) (negative).
  - Exactly -2^(OUT_W-1) is representable and is not a saturation.
  - sat event = saturation applied to a valid sample (Inf included, NaN excluded).
- Counters/flags: update only when the sample advances out of S3 into the output register.
  - sat_cnt increments per sat event and holds at 2^CNT_W-1.
  - clr has priority over a simultaneous event in the same cycle: result is 0/0.
- Reset mid-stream: all in-flight samples are discarded; no partial output appears after reset release.

Optional Feature:
- Macro FLOAT_TO_FIXED_RNE_EN.
- Defined: round-to-nearest, ties-to-even, on magnitude using the guard and sticky bits.
- Undefined: truncate toward zero; guard/sticky are ignored. Saturation still applies to pre-overflow and Inf.

Test Plan:
- Reset, then 10 back-to-back 0x43FA0000 (500.0), o_ready=1, OUT_W=16, FRAC_W=0 -> after 3 cycles 10 consecutive o_data=0x01F4, o_valid high 10 cycles; with FRAC_W=4 -> 0x1F40.
- 0x49742400 (1e6), 0xC9742400 (-1e6), 0x7F800000 (+Inf) -> 0x7FFF, 0x8000, 0x7FFF; sat_cnt=3. Then pulse clr -> sat_cnt=0.
- Rounding: 0x40200000 (2.5), 0x40600000 (3.5), 0xC0200000 (-2.5), 0x46FFFF00 (32767.5).
  - RNE_EN defined -> 0x0002, 0x0004, 0xFFFE, 0x7FFF with sat_cnt+1.
  - Undefined -> 0x0002, 0x0003, 0xFFFE, 0x7FFF (0x46FFFF00 hits no rounding or saturation; sat_cnt unchanged).
- Special values: 0x80000000 (-0), 0x00000001 (denormal), 0x7FC00000 (NaN), 0xC7000000 (-32768.0) -> 0x0000, 0x0000, 0x0000 with nan_flag=1, 0x8000 with no sat increment.
- Backpressure: stream 6 samples with o_ready low for 4 cycles mid-stream -> i_ready low while stalled, o_data held stable, no sample lost or duplicated, output order preserved.
- Assert reset_l=0 with 2 samples in flight -> o_valid drops immediately; after release no output until a new input is accepted, and then 3-cycle latency.

Source files
------------

// File: rtl/float_to_fixed.sv
// float_to_fixed: 3-stage IEEE-754 single to saturating signed fixed-point converter.
// Optional FLOAT_TO_FIXED_RNE_EN selects round-to-nearest-even; the default build truncates toward zero.
module float_to_fixed #(
   parameter int OUT_W  = 16,
   parameter int FRAC_W = 0,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             reset_l,
   input  logic [31:0]      i_signal,
   input  logic             i_valid,
   output logic             i_ready,
   output logic [OUT_W-1:0] o_data,
   output logic             o_valid,
   input  logic             o_ready,
   output logic [CNT_W-1:0] sat_cnt,
   output logic             nan_flag,
   input  logic             clr
);
`ifdef FLOAT_TO_FIXED_RNE_EN
   localparam logic RNE = 1'b1;
`else
   localparam logic RNE = 1'b0;
`endif
   // Shift field: 24-bit significand, up to OUT_W+1 left shifts, integer part sits above bit 25.
   localparam int WW = OUT_W + 26;
   localparam logic signed [9:0] KMAX = 10'(OUT_W - 1);
   localparam logic [OUT_W:0] LIM = {2'b01, {(OUT_W-1){1'b0}}};
   localparam logic [OUT_W-1:0] MAXV = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] MINV = {1'b1, {(OUT_W-1){1'b0}}};
   logic en;
   logic v1_q, s1_q, zero1_q, nan1_q, inf1_q;
   logic [7:0] e1_q;
   logic [23:0] m1_q;
   logic v2_q, s2_q, nan2_q, ovf2_q, g2_q, st2_q;
   logic [OUT_W:0] mag2_q;
   logic ovf2_d, g2_d, st2_d;
   logic [OUT_W:0] mag2_d;
   logic signed [9:0] k;
   logic [WW-1:0] w;
   logic [OUT_W:0] rnd_d;
   logic sat_d;
   logic [OUT_W-1:0] res_d;
   logic o_valid_q, nan_q;
   logic [OUT_W-1:0] o_data_q;
   logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;
   logic nan_d;
   // The whole pipeline advances only when the output register is empty or being drained.
   assign en = ~o_valid_q | o_ready;
   assign i_ready = en;
   assign o_valid = o_valid_q;
   assign o_data = o_data_q;
   assign sat_cnt = sat_cnt_q;
   assign nan_flag = nan_q;
   // S1: unpack fields and classify the encoding.
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         v1_q <= 1'b0;
         s1_q <= 1'b0;
         e1_q <= '0;
         m1_q <= '0;
         zero1_q <= 1'b0;
         nan1_q <= 1'b0;
         inf1_q <= 1'b0;
      end else if (en) begin
         v1_q <= i_valid;
         s1_q <= i_signal[31];
         e1_q <= i_signal[30:23];
         m1_q <= {1'b1, i_signal[22:0]};
         zero1_q <= ~|i_signal[30:23];
         nan1_q <= &i_signal[30:23] & |i_signal[22:0];
         inf1_q <= &i_signal[30:23] & ~|i_signal[22:0];
      end
   end
   // S2 datapath: align significand by scale k, keeping guard and sticky below the integer part.
   always_comb begin
      k = 10'(e1_q) - 10'sd127 + 10'(FRAC_W);
      w = '0;
      mag2_d = '0;
      g2_d = 1'b0;
      st2_d = 1'b0;
      ovf2_d = inf1_q;
      if (!zero1_q && !nan1_q && !inf1_q) begin
         if (k > KMAX) ovf2_d = 1'b1;
         else if (k < -10'sd2) st2_d = 1'b1;
         else begin
            w = WW'(m1_q) << (k + 10'sd2);
            mag2_d = w[WW-1:25];
            g2_d = w[24];
            st2_d = |w[23:0];
         end
      end
   end
   // S2 register.
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         v2_q <= 1'b0;
         s2_q <= 1'b0;
         nan2_q <= 1'b0;
         ovf2_q <= 1'b0;
         mag2_q <= '0;
         g2_q <= 1'b0;
         st2_q <= 1'b0;
      end else if (en) begin
         v2_q <= v1_q;
         s2_q <= s1_q;
         nan2_q <= nan1_q;
         ovf2_q <= ovf2_d;
         mag2_q <= mag2_d;
         g2_q <= g2_d;
         st2_q <= st2_d;
      end
   end
   // S3 datapath: round magnitude, saturate, apply sign; update event counter and NaN flag.
   always_comb begin
      rnd_d = mag2_q + (OUT_W+1)'(RNE & g2_q & (st2_q | mag2_q[0]));
      sat_d = ovf2_q | (s2_q ? rnd_d > LIM : rnd_d > LIM - 1'b1);
      res_d = sat_d ? (s2_q ? MINV : MAXV) : (s2_q ? -rnd_d[OUT_W-1:0] : rnd_d[OUT_W-1:0]);
      sat_cnt_d = clr ? '0 : (en & v2_q & sat_d & ~nan2_q & ~&sat_cnt_q) ? sat_cnt_q + CNT_W'(1) : sat_cnt_q;
      nan_d = clr ? 1'b0 : nan_q | (en & v2_q & nan2_q);
   end
   // Output register and status.
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         o_valid_q <= 1'b0;
         o_data_q <= '0;
         sat_cnt_q <= '0;
         nan_q <= 1'b0;
      end else begin
         if (en) o_valid_q <= v2_q;
         if (en && v2_q) o_data_q <= res_d;
         sat_cnt_q <= sat_cnt_d;
         nan_q <= nan_d;
      end
   end
endmodule
